exibe_sequencia: RTL and testbench

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

---
 rtl/exibe_sequencia_pkg.sv | 20 ++
 rtl/exibe_sequencia_temporizador.sv | 34 +++
 rtl/exibe_sequencia.sv | 110 +++++++++++
 tb/tb_exibe_sequencia.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence player: state encodings and default timings.
package exibe_sequencia_pkg;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        ENDERECA = 4'd1,
        CARREGA  = 4'd2,
        ACENDE   = 4'd3,
        APAGA    = 4'd4,
        FIM      = 4'd5
    } estado_t;

    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Up-counter that flags when it has reached the selected limit; clear wins over count.
module temporizador #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         conta,
    input  logic [W-1:0] limite,
    output logic         fim_contagem
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (limpa) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim_contagem = (cnt_q == limite);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays rodada+1 RAM items on the LEDs, each lit for T_ON cycles and followed by a T_OFF gap.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int T_ON  = T_ON_PADRAO,
    parameter int T_OFF = T_OFF_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
    output logic [3:0] mem_addr,
    input  logic [3:0] mem_dado,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TW = $clog2(max_int(T_ON, T_OFF) + 1);
    // The counter starts at 0, so the last cycle of a phase is limit-1.
    localparam logic [TW-1:0] LIM_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] LIM_OFF = TW'(T_OFF - 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    indice_q, indice_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    leds_q, leds_d;
    logic          tmr_limpa, tmr_conta, tmr_fim;
    logic [TW-1:0] tmr_limite;

    temporizador #(.W(TW)) u_temporizador (
        .clock        (clock),
        .reset        (reset),
        .limpa        (tmr_limpa),
        .conta        (tmr_conta),
        .limite       (tmr_limite),
        .fim_contagem (tmr_fim)
    );

    always_comb begin
        estado_d   = estado_q;
        indice_d   = indice_q;
        rodada_d   = rodada_q;
        leds_d     = leds_q;
        tmr_limpa  = 1'b0;
        tmr_conta  = 1'b0;
        tmr_limite = (estado_q == ACENDE) ? LIM_ON : LIM_OFF;
        unique case (estado_q)
            OCIOSO: begin
                leds_d = '0;
                if (iniciar) begin
                    rodada_d = rodada;
                    indice_d = '0;
                    estado_d = ENDERECA;
                end
            end
            ENDERECA: estado_d = CARREGA;
            CARREGA: begin
                leds_d    = mem_dado;
                tmr_limpa = 1'b1;
                estado_d  = ACENDE;
            end
            ACENDE: begin
                tmr_conta = 1'b1;
                if (tmr_fim) begin
                    leds_d    = '0;
                    tmr_limpa = 1'b1;
                    estado_d  = APAGA;
                end
            end
            APAGA: begin
                tmr_conta = 1'b1;
                if (tmr_fim) begin
                    tmr_limpa = 1'b1;
                    // Index stops at rodada_q (<= 15), so it can never wrap.
                    if (indice_q == rodada_q) begin
                        estado_d = FIM;
                    end else begin
                        indice_d = indice_q + 4'd1;
                        estado_d = ENDERECA;
                    end
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            indice_q <= '0;
            rodada_q <= '0;
            leds_q   <= '0;
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            rodada_q <= rodada_d;
            leds_q   <= leds_d;
        end
    end

    assign mem_addr  = (estado_q == OCIOSO) ? 4'd0 : indice_q;
    assign leds      = leds_q;
    assign exibindo  = (estado_q != OCIOSO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: per-cycle comparison against a timeline computed from item/phase arithmetic.
module tb_exibe_sequencia;

    localparam int TON  = 4;
    localparam int TOFF = 2;
    localparam int P    = 2 + TON + TOFF;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] rodada;
    logic [3:0] mem_addr;
    logic [3:0] mem_dado;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] ram [16];
    int checks = 0;
    int errors = 0;

    exibe_sequencia #(.T_ON(TON), .T_OFF(TOFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .rodada    (rodada),
        .mem_addr  (mem_addr),
        .mem_dado  (mem_dado),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_dado <= ram[mem_addr];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Plays one run of round r; mexe scrambles iniciar/rodada mid-run, aborta (>0) resets at that
    // cycle, segura keeps iniciar high from FIM onward so the next run starts from OCIOSO at once.
    task automatic play(input int r, input bit mexe, input int aborta, input bit segura);
        int total;
        int item;
        int fase;
        logic [3:0] lexp;
        total   = (r + 1) * P + 1;
        rodada  = 4'(r);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int c = 1; c <= total; c++) begin
            item = (c - 1) / P;
            fase = (c - 1) % P;
            if (c == total) begin
                lexp = 4'd0;
                chk("pronto_fim", pronto, 4'd1);
            end else begin
                lexp = (fase >= 2 && fase < 2 + TON) ? ram[item] : 4'd0;
                chk("pronto_run", pronto, 4'd0);
                if (fase == 0) chk("mem_addr", mem_addr, 4'(item));
            end
            chk("leds", leds, lexp);
            chk("exibindo_run", exibindo, 4'd1);
            if (c == aborta) begin
                iniciar = 1'b0;
                reset   = 1'b0;
                step();
                reset = 1'b1;
                chk("abort_leds", leds, 4'd0);
                chk("abort_exibindo", exibindo, 4'd0);
                chk("abort_pronto", pronto, 4'd0);
                chk("abort_addr", mem_addr, 4'd0);
                for (int k = 0; k < 2 * P; k++) begin
                    step();
                    chk("abort_no_pronto", pronto, 4'd0);
                    chk("abort_idle", exibindo, 4'd0);
                end
                return;
            end
            if (mexe) begin
                iniciar = 1'($urandom_range(0, 1));
                rodada  = 4'($urandom_range(0, 15));
            end
            if (segura && c == total) iniciar = 1'b1;
            step();
        end
        chk("idle_exibindo", exibindo, 4'd0);
        chk("idle_pronto", pronto, 4'd0);
        chk("idle_leds", leds, 4'd0);
        chk("idle_addr", mem_addr, 4'd0);
        if (!segura) iniciar = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
        reset   = 1'b0;
        iniciar = 1'b0;
        rodada  = 4'd0;
        step();
        step();
        chk("rst_leds", leds, 4'd0);
        chk("rst_exibindo", exibindo, 4'd0);
        chk("rst_pronto", pronto, 4'd0);
        chk("rst_addr", mem_addr, 4'd0);

        // reset and iniciar at the same edge
        iniciar = 1'b1;
        rodada  = 4'd5;
        step();
        chk("prio_exibindo", exibindo, 4'd0);
        chk("prio_leds", leds, 4'd0);
        iniciar = 1'b0;
        reset   = 1'b1;
        step();
        chk("prio_after", exibindo, 4'd0);

        play(0, 1'b0, 0, 1'b0);
        play(3, 1'b0, 0, 1'b0);
        play(15, 1'b0, 0, 1'b0);
        play(3, 1'b0, 2 * P + 4, 1'b0);
        play(3, 1'b1, 0, 1'b0);
        play(0, 1'b0, 0, 1'b1);
        play(1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            play(int'($urandom_range(0, 15)), 1'b1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
